// File: rtl/booth_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_arbiter
// Description : Round-robin arbiter sharing one Booth mantissa multiplier
//               among NUM_REQ FPU controllers, with a watchdog that aborts
//               an operation whose multiplier never acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int OP_W    = 24,
  parameter int PROD_W  = 2 * OP_W,
  parameter int TIMEOUT = 64,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic [NUM_REQ-1:0]      Req_valid,
  input  logic [NUM_REQ*OP_W-1:0] Req_datain1,
  input  logic [NUM_REQ*OP_W-1:0] Req_datain2,
  output logic [NUM_REQ-1:0]      Req_ack,
  output logic [PROD_W-1:0]       Req_dataout,
  output logic                    Req_err,
  output logic [ID_W-1:0]         Grant_id,
  output logic                    Busy,
  output logic [OP_W-1:0]         Mul_datain1,
  output logic [OP_W-1:0]         Mul_datain2,
  output logic                    Mul_valid,
  input  logic [PROD_W-1:0]       Mul_dataout,
  input  logic                    Mul_ack
);

  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RESP    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t          state;
  logic [ID_W-1:0] last;
  logic [WD_W-1:0] wd_cnt;
  logic [ID_W-1:0] pick;
  logic            any_req;
  logic [NUM_REQ-1:0] ack_onehot;

  // Round-robin pick: first requester set, searching upward from the one after last.
  always_comb begin
    int idx;
    pick    = '0;
    any_req = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (!any_req && Req_valid[idx]) begin
        pick    = ID_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign ack_onehot = NUM_REQ'(1) << Grant_id;

  // Arbitration FSM; every output is a register so the multiplier and the
  // requesters see glitch-free handshakes.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= S_IDLE;
      last        <= ID_W'(NUM_REQ - 1);
      wd_cnt      <= '0;
      Grant_id    <= '0;
      Busy        <= 1'b0;
      Req_ack     <= '0;
      Req_err     <= 1'b0;
      Req_dataout <= '0;
      Mul_valid   <= 1'b0;
      Mul_datain1 <= '0;
      Mul_datain2 <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            Grant_id    <= pick;
            last        <= pick;
            Mul_datain1 <= Req_datain1[pick*OP_W +: OP_W];
            Mul_datain2 <= Req_datain2[pick*OP_W +: OP_W];
            Mul_valid   <= 1'b1;
            wd_cnt      <= '0;
            Busy        <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (Mul_ack) begin
            Req_dataout <= Mul_dataout;
            Mul_valid   <= 1'b0;
            Req_ack     <= ack_onehot;
            Req_err     <= 1'b0;
            state       <= S_RESP;
          end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            // Multiplier is unresponsive: abort with an error completion.
            Req_dataout <= '0;
            Mul_valid   <= 1'b0;
            Req_ack     <= ack_onehot;
            Req_err     <= 1'b1;
            state       <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_RESP: begin
          Req_ack <= '0;
          Req_err <= 1'b0;
          state   <= S_RELEASE;
        end
        S_RELEASE: begin
          // Wait for both the requester and the multiplier to let go, so a
          // held valid cannot re-trigger and a stale ack cannot finish the next op.
          if (!Req_valid[Grant_id] && !Mul_ack) begin
            Busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mul_arbiter
// Description : Scoreboard testbench for booth_mul_arbiter with a behavioural
//               multiplier model and directed requester stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mul_arbiter;

  localparam int NR = 4;
  localparam int OW = 24;
  localparam int PW = 48;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic [NR-1:0] Req_valid = '0;
  logic [NR*OW-1:0] Req_datain1 = '0;
  logic [NR*OW-1:0] Req_datain2 = '0;
  logic [NR-1:0] Req_ack;
  logic [PW-1:0] Req_dataout;
  logic          Req_err;
  logic [1:0]    Grant_id;
  logic          Busy;
  logic [OW-1:0] Mul_datain1;
  logic [OW-1:0] Mul_datain2;
  logic          Mul_valid;
  logic [PW-1:0] Mul_dataout = '0;
  logic          Mul_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  // multiplier model configuration
  int ack_delay = 3;
  int hold_cfg  = 0;
  bit never_ack = 1'b0;
  int mcnt      = 0;
  int hold_left = 0;

  typedef struct {
    int           id;
    logic [PW-1:0] prod;
    logic         err;
  } exp_t;
  exp_t sb[$];

  booth_mul_arbiter #(.NUM_REQ(NR), .OP_W(OW), .PROD_W(PW), .TIMEOUT(64)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .Req_valid(Req_valid), .Req_datain1(Req_datain1), .Req_datain2(Req_datain2),
    .Req_ack(Req_ack), .Req_dataout(Req_dataout), .Req_err(Req_err),
    .Grant_id(Grant_id), .Busy(Busy),
    .Mul_datain1(Mul_datain1), .Mul_datain2(Mul_datain2), .Mul_valid(Mul_valid),
    .Mul_dataout(Mul_dataout), .Mul_ack(Mul_ack)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Behavioural multiplier: acks ack_delay cycles after Mul_valid, holds the
  // ack until Mul_valid falls plus hold_cfg extra cycles.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (!RSTn) begin
        Mul_ack = 1'b0;
        mcnt    = 0;
      end else if (Mul_valid) begin
        if (!never_ack) begin
          mcnt++;
          if (mcnt >= ack_delay && !Mul_ack) begin
            Mul_ack     = 1'b1;
            Mul_dataout = {24'd0, Mul_datain1} * {24'd0, Mul_datain2};
            hold_left   = hold_cfg;
          end
        end
      end else if (Mul_ack && hold_left > 0) begin
        hold_left--;
      end else begin
        Mul_ack = 1'b0;
        mcnt    = 0;
      end
    end
  end

  // Scoreboard monitor: every ack pulse is matched against the oldest expectation.
  always @(negedge CLK) begin
    if (RSTn === 1'b1 && Req_ack !== '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_ack: actual=%b required=none", Req_ack);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ack_onehot", 64'(Req_ack), 64'(4'b0001 << e.id));
        chk("sb_grant_id", 64'(Grant_id), 64'(e.id));
        chk("sb_dataout", 64'(Req_dataout), 64'(e.prod));
        chk("sb_err", 64'(Req_err), 64'(e.err));
      end
    end
  end

  task automatic push(input int id, input logic [PW-1:0] prod, input logic err);
    exp_t e;
    e.id = id; e.prod = prod; e.err = err;
    sb.push_back(e);
  endtask

  task automatic set_op(input int i, input logic [OW-1:0] a, input logic [OW-1:0] b);
    Req_datain1[i*OW +: OW] = a;
    Req_datain2[i*OW +: OW] = b;
  endtask

  // Counts negedges from now until Req_ack, noting when Mul_valid is first seen.
  task automatic wait_ack(output int n_mv, output int n_ack, output logic [NR-1:0] ackv);
    n_mv = -1; n_ack = -1; ackv = '0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge CLK);
      if (Mul_valid && n_mv < 0) n_mv = c;
      if (Req_ack != '0) begin
        n_ack = c;
        ackv  = Req_ack;
        break;
      end
    end
    if (n_ack < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_wait_expired: actual=no_ack required=ack");
    end
  endtask

  task automatic wait_idle(output int n);
    n = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge CLK);
      if (!Busy) begin
        n = c;
        break;
      end
    end
    if (n < 0) begin
      checks++;
      errors++;
      $display("FAIL idle_wait_expired: actual=busy required=idle");
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTn      = 1'b0;
    Req_valid = '0;
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  int mv, ak, ni;
  logic [NR-1:0] av;

  initial begin
    // reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_req_ack", 64'(Req_ack), 0);
    chk("rst_dataout", 64'(Req_dataout), 0);
    chk("rst_err", 64'(Req_err), 0);
    chk("rst_grant", 64'(Grant_id), 0);
    chk("rst_busy", 64'(Busy), 0);
    chk("rst_mul_valid", 64'(Mul_valid), 0);
    chk("rst_mul_a", 64'(Mul_datain1), 0);
    RSTn = 1'b1;
    @(negedge CLK);

    // single operation latency and product
    set_op(0, 24'h800000, 24'hC00000);
    ack_delay = 3;
    push(0, 48'h600000000000, 1'b0);
    Req_valid = 4'b0001;
    wait_ack(mv, ak, av);
    chk("t1_mul_valid_cycle", 64'(mv), 1);
    chk("t1_ack_cycle", 64'(ak), 4);
    Req_valid = '0;
    wait_idle(ni);

    // round-robin fairness with all four requesting
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, 24'(i + 2), 24'h10);
    ack_delay = 2;
    push(0, 48'h20, 1'b0); push(1, 48'h30, 1'b0); push(2, 48'h40, 1'b0);
    push(3, 48'h50, 1'b0); push(0, 48'h20, 1'b0);
    Req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      int gid;
      wait_ack(mv, ak, av);
      gid = int'(Grant_id);
      chk("t2_grant_order", 64'(gid), 64'(j % 4));
      if (j == 4) begin
        Req_valid = '0;
      end else begin
        Req_valid[gid] = 1'b0;
        wait_idle(ni);
        Req_valid[gid] = 1'b1;
      end
    end
    wait_idle(ni);

    // simultaneous requests, operand latching
    do_reset();
    set_op(0, 24'h111111, 24'h2);
    set_op(2, 24'h222222, 24'h2);
    ack_delay = 3;
    push(0, 48'h222222, 1'b0);
    push(2, 48'h444444, 1'b0);
    Req_valid = 4'b0101;
    @(negedge CLK);
    chk("t3_mul_a_first", 64'(Mul_datain1), 64'h111111);
    set_op(0, 24'h333333, 24'h2);
    wait_ack(mv, ak, av);
    chk("t3_mul_a_latched", 64'(Mul_datain1), 64'h111111);
    Req_valid[0] = 1'b0;
    wait_ack(mv, ak, av);
    chk("t3_second_ack", 64'(av), 64'b0100);
    chk("t3_mul_a_second", 64'(Mul_datain1), 64'h222222);
    Req_valid[2] = 1'b0;
    wait_idle(ni);

    // watchdog abort
    never_ack = 1'b1;
    set_op(0, 24'h5, 24'h7);
    push(0, 48'h0, 1'b1);
    Req_valid = 4'b0001;
    wait_ack(mv, ak, av);
    chk("t4_timeout_span", 64'(ak - mv), 64);
    chk("t4_mul_valid_low", 64'(Mul_valid), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("t4_busy_held", 64'(Busy), 1);
    end
    Req_valid = '0;
    @(negedge CLK);
    chk("t4_busy_fall", 64'(Busy), 0);
    never_ack = 1'b0;

    // asynchronous reset during ISSUE
    set_op(1, 24'h9, 24'h9);
    ack_delay = 10;
    Req_valid = 4'b0010;
    repeat (3) @(negedge CLK);
    chk("t5_pre_busy", 64'(Busy), 1);
    RSTn = 1'b0;
    #1;
    chk("t5_rst_mul_valid", 64'(Mul_valid), 0);
    chk("t5_rst_busy", 64'(Busy), 0);
    chk("t5_rst_ack", 64'(Req_ack), 0);
    Req_valid = '0;
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    set_op(0, 24'h3, 24'h3);
    set_op(3, 24'h4, 24'h4);
    ack_delay = 2;
    push(0, 48'h9, 1'b0);
    push(3, 48'h10, 1'b0);
    Req_valid = 4'b1001;
    wait_ack(mv, ak, av);
    chk("t5_first_after_rst", 64'(av), 64'b0001);
    Req_valid[0] = 1'b0;
    wait_ack(mv, ak, av);
    Req_valid[3] = 1'b0;
    wait_idle(ni);

    // requester holding valid after ack; multiplier holding ack
    set_op(0, 24'h6, 24'h7);
    hold_cfg = 0;
    push(0, 48'h2A, 1'b0);
    Req_valid = 4'b0001;
    wait_ack(mv, ak, av);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("t6_no_reissue", 64'(Mul_valid), 0);
      chk("t6_busy_held", 64'(Busy), 1);
    end
    Req_valid = '0;
    wait_idle(ni);
    chk("t6_release_after_drop", 64'(ni), 1);
    hold_cfg = 2;
    set_op(0, 24'h1, 24'h1);
    push(0, 48'h1, 1'b0);
    Req_valid = 4'b0001;
    wait_ack(mv, ak, av);
    Req_valid = '0;
    wait_idle(ni);
    chk("t6_ack_hold_delay", 64'(ni), 3);
    hold_cfg = 0;

    repeat (3) @(negedge CLK);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
